// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic defaults for the serial subtractor and its sibling
// datapath blocks.
package serial_subtractor_pkg;
    localparam int ARITH_W_DEFAULT = 8;
endpackage

// File: rtl/half_subtractor.sv
// Combinational half subtractor: d = x - y, bo = borrow out.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule

// File: rtl/serial_subtractor_fs_cell.sv
// One full-subtractor slice: two half subtractors with their borrows ORed.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    logic d1, b1, b2;

    half_subtractor u_hs0 (.x(x),  .y(y),  .d(d1), .bo(b1));
    half_subtractor u_hs1 (.x(d1), .y(bi), .d(d),  .bo(b2));

    assign bo = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, LSB first, with valid/ready on both sides.
// One fs_cell is reused every RUN cycle; the borrow is held in br_q.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int W = ARITH_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         zero
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic [W-1:0]  res_q, res_d;
    logic          br_q, br_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          zero_q, zero_d;
    logic          slice_d, slice_bo;

    fs_cell u_fs (
        .x (a_sh_q[0]),
        .y (b_sh_q[0]),
        .bi(br_q),
        .d (slice_d),
        .bo(slice_bo)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d  = {slice_d, res_q[W-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = slice_bo;
                // zero is registered alongside the final bit so it is stable in DONE
                zero_d = ({slice_d, res_q[W-1:1]} == '0);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = res_q;
    assign bout      = br_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=8): directed table, corner
// sequences, and randomized operands against an arithmetic reference.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;

    int n_cmp = 0;
    int n_err = 0;

    serial_subtractor #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         z;
        int           stall;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: {bout, diff} is the (W+1)-bit value of a - b - bin.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        return {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                          input int stall, input bit poke,
                          output logic [W-1:0] od, output logic obo, output logic oz,
                          output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("wait_in_ready", 0, 1);
        in_valid = 1'b1; a = ia; b = ib; bin = ibin;
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
        chk("busy_in_ready", 32'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) chk("wait_out_valid", 0, 1);
        od = diff; obo = bout; oz = zero;
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                in_valid = 1'b1; a = 8'h11; b = 8'h01; bin = 1'b0;
            end
            out_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_diff", 32'(diff), 32'(od));
            chk("hold_bout", 32'(bout), 32'(obo));
            chk("hold_zero", 32'(zero), 32'(oz));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", 32'(out_valid), 0);
        chk("post_in_ready", 32'(in_ready), 1);
    endtask

    task automatic check_vs_model(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic ibin, input logic [W-1:0] od, input logic obo, input logic oz);
        logic [W:0] r;
        r = model(ia, ib, ibin);
        chk({nm, "_model_diff"}, 32'(od), 32'(r[W-1:0]));
        chk({nm, "_model_bout"}, 32'(obo), 32'(r[W]));
        chk({nm, "_model_zero"}, 32'(oz), 32'(r[W-1:0] == '0));
    endtask

    initial begin
        vec_t tbl[5];
        logic [W-1:0] od;
        logic obo, oz;
        int lat;
        logic [W-1:0] ra, rb;
        logic rbin;

        tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0};
        tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 0};
        tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1};
        tbl[3] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 0};
        tbl[4] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 2};

        // Reset with a handshake presented on the same edge: it must be dropped.
        rst_n = 1'b0; in_valid = 1'b1; a = 8'h44; b = 8'h22; bin = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_diff", 32'(diff), 0);
        chk("rst_bout", 32'(bout), 0);
        chk("rst_zero", 32'(zero), 0);
        @(negedge clk);
        chk("rst_no_accept", 32'(in_ready), 1);

        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].stall, 1'b0, od, obo, oz, lat);
            chk($sformatf("tbl%0d_diff", i), 32'(od), 32'(tbl[i].d));
            chk($sformatf("tbl%0d_bout", i), 32'(obo), 32'(tbl[i].bo));
            chk($sformatf("tbl%0d_zero", i), 32'(oz), 32'(tbl[i].z));
            chk($sformatf("tbl%0d_latency", i), 32'(lat), W);
            check_vs_model($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin, od, obo, oz);
        end

        // Stall in DONE for 5 cycles while a new request is offered.
        run_op(8'h5A, 8'h5A, 1'b0, 5, 1'b1, od, obo, oz, lat);
        chk("stall_diff", 32'(od), 0);
        chk("stall_zero", 32'(oz), 1);
        run_op(8'h11, 8'h01, 1'b0, 0, 1'b0, od, obo, oz, lat);
        chk("after_stall_diff", 32'(od), 32'h10);
        chk("after_stall_bout", 32'(obo), 0);

        // Reset mid-RUN abandons the operation.
        in_valid = 1'b1; a = 8'hF0; b = 8'h0F; bin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_diff", 32'(diff), 0);
        chk("midrst_bout", 32'(bout), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        run_op(8'h10, 8'h01, 1'b0, 0, 1'b0, od, obo, oz, lat);
        chk("midrst_next_diff", 32'(od), 32'h0F);
        chk("midrst_next_bout", 32'(obo), 0);

        for (int k = 0; k < 200; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rbin = 1'($urandom);
            run_op(ra, rb, rbin, int'($urandom_range(0, 3)), 1'b0, od, obo, oz, lat);
            check_vs_model("rand", ra, rb, rbin, od, obo, oz);
            chk("rand_latency", 32'(lat), W);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial W-bit subtractor computing diff = a - b - bin one bit per clock, LSB first. It is the sequential stage built directly on top of the combinational half-subtractor cell: two half subtractors form one full-subtractor slice, and a registered borrow carries between bit positions. Operands enter through a valid/ready handshake. The result is held on a valid/ready output until it is consumed. It is the area-cheap alternative to a W-bit ripple subtractor in the arithmetic datapath.

## Interface
- W, 8, operand and result width (W >= 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operands a, b, bin are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  W  minuend
- b  input  W  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  diff, bout and zero are valid
- out_ready  input  1  downstream consumes the result
- diff  output  W  a - b - bin, modulo 2^W
- bout  output  1  borrow out (1 when a < b + bin, unsigned)
- zero  output  1  diff == 0

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge where in_valid && in_ready: load a_sh <= a, b_sh <= b, br <= bin, cnt <= 0; go to RUN.
- RUN:
  - Each cycle the slice computes d = a_sh[0] ^ b_sh[0] ^ br and nb = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br).
  - Register updates: res <= {d, res[W-1:1]}; a_sh and b_sh shift right by 1; br <= nb; cnt <= cnt + 1.
  - When cnt == W-1, take the last step and go to DONE.
  - cnt is $clog2(W) bits wide and never wraps past W-1.
- DONE:
  - out_valid = 1; diff = res; bout = br; zero = (res == 0).
  - On an edge where out_valid && out_ready, go to IDLE.
- in_valid is ignored outside IDLE, and a, b, bin are sampled only on the accept edge.
- Outputs are registered. diff, bout and zero must not change while out_valid is high.
- Unsigned arithmetic throughout. {bout, diff} equals the (W+1)-bit two's-complement value of a - b - bin.

## Timing
- Reset (rst_n low at a rising edge):
  - state goes to IDLE; out_valid, diff, bout, zero, cnt and br go to 0.
  - in_ready is 1 from the first cycle after reset.
  - A handshake coinciding with the reset edge is discarded.
- Reset in RUN or DONE abandons the operation. No partial result appears.
- Latency: operands accepted at edge 0 give out_valid high after edge W, so it is visible in the cycle following edge W.
- Peak throughput is one operation per W+2 cycles: one accept cycle, W RUN cycles, at least one DONE cycle.
- Back-to-back: DONE consuming at edge k means in_ready is high in the cycle after edge k. The accept cannot happen on edge k itself.
- out_ready held low stalls indefinitely in DONE with stable outputs. in_ready stays 0.
- in_valid high during RUN or DONE has no effect. The upstream must hold its data until in_ready.

## Structure
- Sub-module fs_cell: a combinational full subtractor (x, y, bi -> d, bo) built from two instances of the existing half-subtractor cell plus an OR gate. serial_subtractor instantiates exactly one fs_cell.
- State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) are local parameters of serial_subtractor.
- The default width W=8 goes in the shared arithmetic defines header used by the other arithmetic blocks.

## Test plan
All scenarios use W=8. Every case is also checked against a behavioural model of {bout, diff} = a - b - bin, including 200 random operand sets with random out_ready gaps.
- a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, zero=0; out_valid rises exactly 8 edges after the accept edge.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, zero=0.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0, zero=1.
- a=0x5A, b=0x5A, bin=0 with out_ready held low for 5 cycles:
  - diff=0x00, zero=1, out_valid held high and outputs stable throughout;
  - in_ready=0, and a new in_valid with a=0x11 is not accepted;
  - after out_ready=1, IDLE is re-entered, 0x11 is accepted and its result is correct.
- rst_n low for one edge during RUN cycle 3 of a=0xF0, b=0x0F:
  - out_valid=0, diff=0, bout=0, in_ready=1 in the following cycle;
  - a subsequent a=0x10, b=0x01, bin=0 gives diff=0x0F, bout=0.
